// File: rtl/iir_pair_packer.sv
// Serial-to-parallel packer: turns a one-sample-per-cycle stream into registered
// (x[2k], x[2k+1]) pairs for the 2-unfolded IIR, with flush padding and a pair counter.
module iir_pair_packer #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [DW-1:0] pair_x2k,
  output logic [DW-1:0] pair_x2k1,
  output logic          pair_valid,
  input  logic          pair_ready,
  output logic          pair_pad,
  output logic [CW-1:0] pair_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_x2k;
  logic [DW-1:0] r_x2k1;
  logic          r_valid;
  logic          r_pad;
  logic [CW-1:0] r_cnt;

  logic w_slot_free;
  logic w_accept;
  logic w_handoff;
  logic w_lo_load;
  logic w_load;
  logic w_load_pad;

  // The slot frees in the same cycle the IIR takes the current pair, so a
  // completed pair can replace it without a bubble.
  assign w_slot_free = !r_valid || pair_ready;
  assign w_handoff   = r_valid && pair_ready;
  assign in_ready    = !rst && !((r_state == HALF) && !w_slot_free);
  assign w_accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lo_load   = 1'b0;
    w_load      = 1'b0;
    w_load_pad  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_lo_load   = 1'b1;
          w_state_nxt = HALF;
        end
      end
      HALF: begin
        // An accepted odd sample takes priority over flush.
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = EMPTY;
        end else if (flush && w_slot_free) begin
          w_load      = 1'b1;
          w_load_pad  = 1'b1;
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo    <= '0;
      r_x2k   <= '0;
      r_x2k1  <= '0;
      r_valid <= 1'b0;
      r_pad   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_lo_load) begin
        r_lo <= in_data;
      end
      if (w_load) begin
        r_x2k   <= r_lo;
        r_x2k1  <= w_load_pad ? '0 : in_data;
        r_pad   <= w_load_pad;
        r_valid <= 1'b1;
      end else if (w_handoff) begin
        r_valid <= 1'b0;
      end
      if (w_handoff) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pair_x2k   = r_x2k;
  assign pair_x2k1  = r_x2k1;
  assign pair_valid = r_valid;
  assign pair_pad   = r_pad;
  assign pair_cnt   = r_cnt;

endmodule

// File: tb/tb_iir_pair_packer.sv
// Directed bench for iir_pair_packer; a second narrow-counter instance shares the
// stimulus so counter wrap can be seen without tens of thousands of handoffs.
module tb_iir_pair_packer;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int CWS = 4;

  logic           clk;
  logic           rst;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [DW-1:0]  pair_x2k;
  logic [DW-1:0]  pair_x2k1;
  logic           pair_valid;
  logic           pair_ready;
  logic           pair_pad;
  logic [CW-1:0]  pair_cnt;

  logic           s_in_ready;
  logic [DW-1:0]  s_x2k;
  logic [DW-1:0]  s_x2k1;
  logic           s_valid;
  logic           s_pad;
  logic [CWS-1:0] s_cnt;

  int checks;
  int errors;

  iir_pair_packer #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .pair_x2k   (pair_x2k),
    .pair_x2k1  (pair_x2k1),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .pair_pad   (pair_pad),
    .pair_cnt   (pair_cnt)
  );

  iir_pair_packer #(.DW(DW), .CW(CWS)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .flush      (flush),
    .pair_x2k   (s_x2k),
    .pair_x2k1  (s_x2k1),
    .pair_valid (s_valid),
    .pair_ready (pair_ready),
    .pair_pad   (s_pad),
    .pair_cnt   (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair(input string tag, input logic [7:0] x0, input logic [7:0] x1,
                            input logic pad);
    check_eq({tag, "_vld"}, 32'(pair_valid), 32'd1);
    check_eq({tag, "_x2k"}, 32'(pair_x2k), 32'(x0));
    check_eq({tag, "_x2k1"}, 32'(pair_x2k1), 32'(x1));
    check_eq({tag, "_pad"}, 32'(pair_pad), 32'(pad));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    flush      = 1'b0;
    pair_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst_vld", 32'(pair_valid), 32'd0);
    check_eq("rst_x2k", 32'(pair_x2k), 32'd0);
    check_eq("rst_x2k1", 32'(pair_x2k1), 32'd0);
    check_eq("rst_pad", 32'(pair_pad), 32'd0);
    check_eq("rst_cnt", 32'(pair_cnt), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Test 1: stream 01..06
    in_valid = 1'b1;
    in_data = 8'h01; tick();
    check_eq("t1_vld_after_even", 32'(pair_valid), 32'd0);
    in_data = 8'h02; tick();
    check_pair("t1_p0", 8'h01, 8'h02, 1'b0);
    check_eq("t1_cnt0", 32'(pair_cnt), 32'd0);
    in_data = 8'h03; tick();
    check_eq("t1_vld_gap", 32'(pair_valid), 32'd0);
    check_eq("t1_cnt1", 32'(pair_cnt), 32'd1);
    in_data = 8'h04; tick();
    check_pair("t1_p1", 8'h03, 8'h04, 1'b0);
    in_data = 8'h05; tick();
    in_data = 8'h06; tick();
    check_pair("t1_p2", 8'h05, 8'h06, 1'b0);
    in_valid = 1'b0; tick();
    check_eq("t1_cnt3", 32'(pair_cnt), 32'd3);
    check_eq("t1_vld_end", 32'(pair_valid), 32'd0);

    // Test 2: back-pressure
    in_valid = 1'b1;
    in_data = 8'h10; tick();
    in_data = 8'h11; tick();
    check_pair("t2_p0", 8'h10, 8'h11, 1'b0);
    pair_ready = 1'b0;
    in_data = 8'h12; #1;
    check_eq("t2_rdy_even", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h13;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t2_rdy_odd_stall", 32'(in_ready), 32'd0);
      tick();
      check_pair("t2_hold", 8'h10, 8'h11, 1'b0);
      check_eq("t2_cnt_hold", 32'(pair_cnt), 32'd3);
    end
    pair_ready = 1'b1; #1;
    check_eq("t2_rdy_release", 32'(in_ready), 32'd1);
    tick();
    check_pair("t2_p1", 8'h12, 8'h13, 1'b0);
    check_eq("t2_cnt4", 32'(pair_cnt), 32'd4);
    in_valid = 1'b0; tick();
    check_eq("t2_cnt5", 32'(pair_cnt), 32'd5);
    check_eq("t2_vld_end", 32'(pair_valid), 32'd0);

    // Test 3: flush pads odd trailing sample
    in_valid = 1'b1; in_data = 8'h7F; tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    check_pair("t3_pad", 8'h7F, 8'h00, 1'b1);
    tick();
    check_eq("t3_cnt6", 32'(pair_cnt), 32'd6);
    check_eq("t3_vld_end", 32'(pair_valid), 32'd0);

    // Test 4: flush in EMPTY, flush with odd sample, flush with even sample
    flush = 1'b1; tick(); tick();
    check_eq("t4_empty_flush_vld", 32'(pair_valid), 32'd0);
    check_eq("t4_empty_flush_cnt", 32'(pair_cnt), 32'd6);
    flush = 1'b0; in_valid = 1'b1; in_data = 8'h21; tick();
    flush = 1'b1; in_data = 8'h22; tick();
    check_pair("t4_odd_flush", 8'h21, 8'h22, 1'b0);
    in_data = 8'h31; tick();
    check_eq("t4_even_flush_vld", 32'(pair_valid), 32'd0);
    check_eq("t4_cnt7", 32'(pair_cnt), 32'd7);
    in_valid = 1'b0; tick();
    flush = 1'b0;
    check_pair("t4_even_then_pad", 8'h31, 8'h00, 1'b1);
    tick();
    check_eq("t4_cnt8", 32'(pair_cnt), 32'd8);

    // Test 5: reset mid-operation with a pending pair and half pair
    pair_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h41; tick();
    in_data = 8'h42; tick();
    in_data = 8'hAA; tick();
    check_pair("t5_pending", 8'h41, 8'h42, 1'b0);
    in_valid = 1'b0; rst = 1'b1; #1;
    check_eq("t5_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    check_eq("t5_rst_vld", 32'(pair_valid), 32'd0);
    check_eq("t5_rst_x2k", 32'(pair_x2k), 32'd0);
    check_eq("t5_rst_x2k1", 32'(pair_x2k1), 32'd0);
    check_eq("t5_rst_cnt", 32'(pair_cnt), 32'd0);
    pair_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'h01; tick();
    check_eq("t5_no_emit", 32'(pair_valid), 32'd0);
    in_data = 8'h02; tick();
    check_pair("t5_p0", 8'h01, 8'h02, 1'b0);
    in_valid = 1'b0; tick();
    check_eq("t5_cnt1", 32'(pair_cnt), 32'd1);

    // Test 6: counter wrap on the narrow instance
    in_valid = 1'b1;
    for (int i = 0; i < 28; i++) begin
      in_data = 8'(i + 8'h50);
      tick();
    end
    in_valid = 1'b0; tick();
    check_eq("t6_cnt15", 32'(pair_cnt), 32'd15);
    check_eq("t6_small_max", 32'(s_cnt), 32'hF);
    in_valid = 1'b1;
    in_data = 8'hE0; tick();
    in_data = 8'hE1; tick();
    check_eq("t6_small_x2k1", 32'(s_x2k1), 32'hE1);
    in_valid = 1'b0; tick();
    check_eq("t6_cnt16", 32'(pair_cnt), 32'd16);
    check_eq("t6_small_wrap", 32'(s_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
